// File: rtl/round_robin_ctrl.sv
// round_robin_ctrl: round-robin drain of four upstream FIFOs into one
// downstream FIFO, with pause/resume on the downstream almost-full and
// almost-empty flags.
// Optional feature macro: RR_ERROR_HOLD_EN -- when defined, any error_in bit
// drives the controller into a sticky ERROR state that only reset clears;
// when undefined, error_in is ignored and ERROR is never entered.
module round_robin_ctrl #(
   parameter int unsigned DW = 6,
   parameter int unsigned N  = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  fifo_empty,
   input  logic [DW-1:0] data_in_0,
   input  logic [DW-1:0] data_in_1,
   input  logic [DW-1:0] data_in_2,
   input  logic [DW-1:0] data_in_3,
   input  logic [N-1:0]  valid_in,
   input  logic [N-1:0]  error_in,
   input  logic          almost_full_in,
   input  logic          almost_empty_in,
   output logic [N-1:0]  pop,
   output logic          push_out,
   output logic [DW-1:0] data_out,
   output logic [1:0]    grant_id,
   output logic [1:0]    state_out
);

   localparam int unsigned GW = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      PAUSE  = 2'd2,
      ERROR  = 2'd3
   } state_e;

   state_e          state, state_nxt;
   logic            pause_q, pause_nxt;
   logic [N-1:0]    pop_d, pop_d_nxt;
   logic [N-1:0]    pop_nxt;
   logic            push_nxt;
   logic [DW-1:0]   data_nxt;
   logic [GW-1:0]   grant_nxt;

   logic [N-1:0]    eligible_c;
   logic [N-1:0]    nonempty_c;
   logic            err_c;
   logic            grant_found_c;
   logic [GW-1:0]   grant_idx_c;
   logic            grant_ok_c;
   logic [GW-1:0]   pop_idx_c;
   logic [DW-1:0]   data_sel_c;

`ifdef RR_ERROR_HOLD_EN
   assign err_c = |error_in;
`else
   logic unused_error_c;
   assign err_c          = 1'b0;
   assign unused_error_c = |error_in;
`endif

   // A FIFO popped last cycle may still show a stale non-empty flag, so skip it
   assign nonempty_c = ~fifo_empty;
   assign eligible_c = nonempty_c & ~pop;

   // Latch set wins over clear when both flags arrive together
   assign pause_nxt = almost_full_in | (pause_q & ~almost_empty_in);

   assign state_out = state;

   // Round-robin search starting one past the last grant, wrapping at N
   always_comb begin
      logic [GW-1:0] cand;
      cand          = '0;
      grant_found_c = 1'b0;
      grant_idx_c   = grant_id;
      for (int unsigned k = 1; k <= N; k++) begin
         cand = grant_id + GW'(k);
         if (!grant_found_c && eligible_c[cand]) begin
            grant_found_c = 1'b1;
            grant_idx_c   = cand;
         end
      end
   end

   // Index and data of the FIFO popped in the previous cycle
   always_comb begin
      pop_idx_c = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (pop_d[i]) pop_idx_c = GW'(i);
      end
      case (pop_idx_c)
         2'd1:    data_sel_c = data_in_1;
         2'd2:    data_sel_c = data_in_2;
         2'd3:    data_sel_c = data_in_3;
         default: data_sel_c = data_in_0;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; ACTIVE is held while a requester is merely waiting out
   // its one-cycle post-grant exclusion, so a lone requester pops every other cycle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (pause_q)          state_nxt = PAUSE;
            else if (|eligible_c) state_nxt = ACTIVE;
         end
         ACTIVE: begin
            if (pause_q)          state_nxt = PAUSE;
            else if (~|nonempty_c) state_nxt = IDLE;
         end
         PAUSE: begin
            if (!pause_q) state_nxt = (|eligible_c) ? ACTIVE : IDLE;
         end
         ERROR:   state_nxt = ERROR;
         default: state_nxt = IDLE;
      endcase
      if (err_c) state_nxt = ERROR;
   end

   // Output logic: next values of pop, push, data and grant
   always_comb begin
      pop_nxt   = '0;
      push_nxt  = 1'b0;
      data_nxt  = data_out;
      grant_nxt = grant_id;
      pop_d_nxt = pop;
      // No new grant while a pause is pending so at most two pushes follow almost_full
      grant_ok_c = (state == ACTIVE) && (state_nxt == ACTIVE) && !pause_q &&
                   !almost_full_in && grant_found_c;
      if (grant_ok_c) begin
         pop_nxt   = N'(1) << grant_idx_c;
         grant_nxt = grant_idx_c;
      end
      if ((|pop_d) && valid_in[pop_idx_c]) begin
         push_nxt = 1'b1;
         data_nxt = data_sel_c;
      end
      if (state_nxt == ERROR) begin
         pop_nxt   = '0;
         push_nxt  = 1'b0;
         pop_d_nxt = '0;
      end
   end

   // Registered outputs, pause latch and in-flight pop tracking
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pop      <= '0;
         pop_d    <= '0;
         push_out <= 1'b0;
         data_out <= '0;
         grant_id <= GW'(N - 1);
         pause_q  <= 1'b0;
      end else begin
         pop      <= pop_nxt;
         pop_d    <= pop_d_nxt;
         push_out <= push_nxt;
         data_out <= data_nxt;
         grant_id <= grant_nxt;
         pause_q  <= pause_nxt;
      end
   end

endmodule

// File: tb/tb_round_robin_ctrl.sv
// Directed testbench for round_robin_ctrl. Expectations for the error case
// follow the RR_ERROR_HOLD_EN macro as seen by this compile.
module tb_round_robin_ctrl;

   localparam int unsigned DW = 6;
   localparam int unsigned N  = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  fifo_empty;
   logic [DW-1:0] data_in_0, data_in_1, data_in_2, data_in_3;
   logic [N-1:0]  valid_in;
   logic [N-1:0]  error_in;
   logic          almost_full_in;
   logic          almost_empty_in;
   logic [N-1:0]  pop;
   logic          push_out;
   logic [DW-1:0] data_out;
   logic [1:0]    grant_id;
   logic [1:0]    state_out;

   int vectors     = 0;
   int miscompares = 0;
   logic [DW-1:0] dv [4];

   round_robin_ctrl #(.DW(DW), .N(N)) dut (
      .clk             (clk),
      .reset           (reset),
      .fifo_empty      (fifo_empty),
      .data_in_0       (data_in_0),
      .data_in_1       (data_in_1),
      .data_in_2       (data_in_2),
      .data_in_3       (data_in_3),
      .valid_in        (valid_in),
      .error_in        (error_in),
      .almost_full_in  (almost_full_in),
      .almost_empty_in (almost_empty_in),
      .pop             (pop),
      .push_out        (push_out),
      .data_out        (data_out),
      .grant_id        (grant_id),
      .state_out       (state_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      dv[0] = 6'h0A; dv[1] = 6'h15; dv[2] = 6'h2A; dv[3] = 6'h3F;
      data_in_0 = dv[0]; data_in_1 = dv[1]; data_in_2 = dv[2]; data_in_3 = dv[3];
      reset = 1'b1; fifo_empty = 4'hF; valid_in = 4'h0; error_in = 4'h0;
      almost_full_in = 1'b0; almost_empty_in = 1'b0;

      // Reset values
      tick();
      chk("rst_state", 32'(state_out), 32'd0);
      chk("rst_pop",   32'(pop),       32'd0);
      chk("rst_push",  32'(push_out),  32'd0);
      chk("rst_data",  32'(data_out),  32'd0);
      chk("rst_grant", 32'(grant_id),  32'd3);

      // All requesters non-empty: rotate 0,1,2,3,0 with push two cycles after pop
      reset = 1'b0; fifo_empty = 4'h0; valid_in = 4'hF;
      tick();
      chk("all_c1_state", 32'(state_out), 32'd1);
      chk("all_c1_pop",   32'(pop),       32'd0);
      for (int k = 2; k <= 7; k++) begin
         tick();
         if (k <= 6) begin
            chk($sformatf("all_c%0d_pop", k),   32'(pop),      32'(4'b0001 << ((k - 2) % 4)));
            chk($sformatf("all_c%0d_grant", k), 32'(grant_id), 32'((k - 2) % 4));
         end
         chk($sformatf("all_c%0d_push", k), 32'(push_out), (k >= 4) ? 32'd1 : 32'd0);
         if (k >= 4)
            chk($sformatf("all_c%0d_data", k), 32'(data_out), 32'(dv[(k - 4) % 4]));
      end

      // Only requester 2 non-empty: popped every other cycle
      reset = 1'b1; tick();
      reset = 1'b0; fifo_empty = 4'b1011; valid_in = 4'hF;
      tick(); tick();
      chk("one_c2_pop",   32'(pop),       32'h4);
      chk("one_c2_grant", 32'(grant_id),  32'd2);
      tick();
      chk("one_c3_pop",   32'(pop),       32'h0);
      chk("one_c3_state", 32'(state_out), 32'd1);
      chk("one_c3_grant", 32'(grant_id),  32'd2);
      tick();
      chk("one_c4_pop",   32'(pop),       32'h4);
      chk("one_c4_push",  32'(push_out),  32'd1);
      chk("one_c4_data",  32'(data_out),  32'(dv[2]));
      tick();
      chk("one_c5_pop",   32'(pop),       32'h0);
      chk("one_c5_push",  32'(push_out),  32'd0);
      tick();
      chk("one_c6_pop",   32'(pop),       32'h4);
      chk("one_c6_push",  32'(push_out),  32'd1);

      // Pause on almost_full pulse, resume on almost_empty pulse
      reset = 1'b1; tick();
      reset = 1'b0; fifo_empty = 4'h0; valid_in = 4'hF;
      tick(); tick(); tick(); tick();
      chk("pz_c4_pop",   32'(pop),      32'h4);
      chk("pz_c4_grant", 32'(grant_id), 32'd2);
      almost_full_in = 1'b1;
      tick();
      almost_full_in = 1'b0;
      chk("pz_c5_pop",   32'(pop),       32'h0);
      chk("pz_c5_push",  32'(push_out),  32'd1);
      chk("pz_c5_data",  32'(data_out),  32'(dv[1]));
      chk("pz_c5_state", 32'(state_out), 32'd1);
      tick();
      chk("pz_c6_pop",   32'(pop),       32'h0);
      chk("pz_c6_push",  32'(push_out),  32'd1);
      chk("pz_c6_data",  32'(data_out),  32'(dv[2]));
      chk("pz_c6_state", 32'(state_out), 32'd2);
      tick();
      chk("pz_c7_pop",   32'(pop),       32'h0);
      chk("pz_c7_push",  32'(push_out),  32'd0);
      chk("pz_c7_state", 32'(state_out), 32'd2);
      tick();
      chk("pz_c8_state", 32'(state_out), 32'd2);
      almost_empty_in = 1'b1;
      tick();
      almost_empty_in = 1'b0;
      chk("pz_c9_state", 32'(state_out), 32'd2);
      chk("pz_c9_pop",   32'(pop),       32'h0);
      tick();
      chk("pz_c10_state", 32'(state_out), 32'd1);
      chk("pz_c10_pop",   32'(pop),       32'h0);
      tick();
      chk("pz_c11_pop",   32'(pop),       32'h8);
      chk("pz_c11_grant", 32'(grant_id),  32'd3);
      tick();
      chk("pz_c12_pop",   32'(pop),       32'h1);

      // Error input while flowing
      error_in = 4'b0100;
      tick();
      error_in = 4'b0000;
`ifdef RR_ERROR_HOLD_EN
      chk("err_c13_state", 32'(state_out), 32'd3);
      chk("err_c13_pop",   32'(pop),       32'h0);
      chk("err_c13_push",  32'(push_out),  32'd0);
      for (int k = 14; k <= 15; k++) begin
         tick();
         chk($sformatf("err_c%0d_state", k), 32'(state_out), 32'd3);
         chk($sformatf("err_c%0d_pop", k),   32'(pop),       32'h0);
         chk($sformatf("err_c%0d_push", k),  32'(push_out),  32'd0);
      end
`else
      chk("err_c13_state", 32'(state_out), 32'd1);
      chk("err_c13_pop",   32'(pop),       32'h2);
      chk("err_c13_push",  32'(push_out),  32'd1);
      chk("err_c13_data",  32'(data_out),  32'(dv[3]));
      tick();
      chk("err_c14_pop",   32'(pop),       32'h4);
      chk("err_c14_data",  32'(data_out),  32'(dv[0]));
      tick();
      chk("err_c15_pop",   32'(pop),       32'h8);
      chk("err_c15_state", 32'(state_out), 32'd1);
`endif

      // Reset in the middle of a transfer discards in-flight data
      reset = 1'b1; tick();
      reset = 1'b0; fifo_empty = 4'h0; valid_in = 4'hF;
      tick(); tick();
      chk("mid_c2_pop", 32'(pop), 32'h1);
      tick();
      reset = 1'b1;
      #1;
      chk("mid_rst_pop",   32'(pop),       32'h0);
      chk("mid_rst_push",  32'(push_out),  32'd0);
      chk("mid_rst_data",  32'(data_out),  32'd0);
      chk("mid_rst_grant", 32'(grant_id),  32'd3);
      chk("mid_rst_state", 32'(state_out), 32'd0);
      tick();
      reset = 1'b0; fifo_empty = 4'hF;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("mid_post%0d_push", k), 32'(push_out), 32'd0);
         chk($sformatf("mid_post%0d_pop", k),  32'(pop),      32'h0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
